// File: rtl/tpu_host_pkg.sv
// Shared types and defaults for the TPU host-side pin driver.
// The optional result watchdog is enabled by defining TPU_HOST_TIMEOUT_EN.
package tpu_host_pkg;

    localparam int unsigned KERNEL_LEN_DEF     = 4;
    localparam int unsigned MATRIX_LEN_DEF     = 16;
    localparam int unsigned RESULT_LEN_DEF     = 9;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        StIdle,
        StKernel,
        StMatrix,
        StGo,
        StWaitDone,
        StCapture,
        StDrain
    } state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tpu_host_result_buf.sv
// Result byte store: written in capture order, read back in the same order.
// Counts (not wrapping pointers) so that full and empty are unambiguous.
module tpu_host_result_buf
    import tpu_host_pkg::*;
#(
    parameter int unsigned RESULT_LEN = RESULT_LEN_DEF
) (
    input  logic  i_clock,
    input  logic  i_reset_n,
    input  logic  i_clear,
    input  logic  i_wr_en,
    input  byte_t i_wr_data,
    input  logic  i_rd_en,
    output byte_t o_rd_data,
    output logic  o_full,
    output logic  o_empty
);

    localparam int unsigned IDX_W = clog2_min1(RESULT_LEN);
    localparam int unsigned CNT_W = $clog2(RESULT_LEN + 1);

    byte_t            r_mem [RESULT_LEN];
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] r_rd_cnt;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else if (i_clear) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (i_wr_en && !o_full) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (i_rd_en && !o_empty) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end
    end

    // Storage needs no reset: stale entries are unreachable once the counts clear.
    always_ff @(posedge i_clock) begin
        if (i_wr_en && !o_full) begin
            r_mem[r_wr_cnt[IDX_W-1:0]] <= i_wr_data;
        end
    end

    assign o_full    = (r_wr_cnt == CNT_W'(RESULT_LEN));
    assign o_empty   = (r_rd_cnt == r_wr_cnt);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_cnt[IDX_W-1:0]];

endmodule

// File: rtl/tpu_host_driver.sv
// Host-side driver for the TPU pin interface: streams a job in, collects the result, replays it.
// Define TPU_HOST_TIMEOUT_EN to build the result watchdog that drives o_error.
module tpu_host_driver
    import tpu_host_pkg::*;
#(
    parameter int unsigned KERNEL_LEN     = KERNEL_LEN_DEF,
    parameter int unsigned MATRIX_LEN     = MATRIX_LEN_DEF,
    parameter int unsigned RESULT_LEN     = RESULT_LEN_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic  i_clock,
    input  logic  i_reset_n,
    input  logic  i_start,
    output logic  o_busy,
    input  byte_t i_in_data,
    input  logic  i_in_valid,
    output logic  o_in_ready,
    output byte_t o_res_data,
    output logic  o_res_valid,
    input  logic  i_res_ready,
    output logic  o_tpu_insert_kernal,
    output logic  o_tpu_insert_matrix,
    output logic  o_tpu_ready,
    output byte_t o_tpu_data,
    input  logic  i_tpu_done,
    input  byte_t i_tpu_result,
    output logic  o_error
);

    localparam int unsigned KW    = clog2_min1(KERNEL_LEN);
    localparam int unsigned MW    = clog2_min1(MATRIX_LEN);
    localparam int unsigned RW    = clog2_min1(RESULT_LEN);
    localparam int unsigned KMW   = (KW > MW) ? KW : MW;
    localparam int unsigned CNT_W = (KMW > RW) ? KMW : RW;

    state_e           r_state,      w_state_d;
    logic [CNT_W-1:0] r_cnt,        w_cnt_d;
    byte_t            r_tpu_data,   w_tpu_data_d;
    logic             r_ins_k,      w_ins_k_d;
    logic             r_ins_m,      w_ins_m_d;
    logic             r_tpu_ready,  w_tpu_ready_d;
    logic             r_res_valid,  w_res_valid_d;
    logic             r_error,      w_error_d;

    logic  w_accept;
    logic  w_res_hs;
    logic  w_timeout;
    logic  w_buf_clear;
    logic  w_buf_wr;
    logic  w_buf_rd;
    logic  w_buf_full;
    logic  w_buf_empty;
    byte_t w_buf_rd_data;

    assign o_in_ready = (r_state == StKernel) || (r_state == StMatrix);
    assign o_busy     = (r_state != StIdle);
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_res_hs   = (r_state == StDrain) && r_res_valid && i_res_ready;

`ifdef TPU_HOST_TIMEOUT_EN
    localparam int unsigned WD_W = clog2_min1(TIMEOUT_CYCLES);

    logic [WD_W-1:0] r_wdog;

    // Zero at the tpu_ready pulse (first WAIT_DONE cycle); fires on its last allowed cycle.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wdog <= '0;
        end else if ((r_state == StWaitDone) || (r_state == StCapture)) begin
            r_wdog <= r_wdog + 1'b1;
        end else begin
            r_wdog <= '0;
        end
    end

    assign w_timeout = (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_tpu_data  <= '0;
            r_ins_k     <= 1'b0;
            r_ins_m     <= 1'b0;
            r_tpu_ready <= 1'b0;
            r_res_valid <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_tpu_data  <= w_tpu_data_d;
            r_ins_k     <= w_ins_k_d;
            r_ins_m     <= w_ins_m_d;
            r_tpu_ready <= w_tpu_ready_d;
            r_res_valid <= w_res_valid_d;
            r_error     <= w_error_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_tpu_data_d  = r_tpu_data;
        w_ins_k_d     = 1'b0;
        w_ins_m_d     = 1'b0;
        w_tpu_ready_d = 1'b0;
        w_res_valid_d = 1'b0;
        w_error_d     = r_error;
        w_buf_clear   = 1'b0;
        w_buf_wr      = 1'b0;
        w_buf_rd      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d   = StKernel;
                    w_cnt_d     = '0;
                    w_error_d   = 1'b0;
                    w_buf_clear = 1'b1;
                end
            end
            StKernel: begin
                if (w_accept) begin
                    w_tpu_data_d = i_in_data;
                    w_ins_k_d    = 1'b1;
                    if (r_cnt == CNT_W'(KERNEL_LEN - 1)) begin
                        w_state_d = StMatrix;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            end
            StMatrix: begin
                if (w_accept) begin
                    w_tpu_data_d = i_in_data;
                    w_ins_m_d    = 1'b1;
                    if (r_cnt == CNT_W'(MATRIX_LEN - 1)) begin
                        w_state_d = StGo;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            end
            StGo: begin
                w_tpu_ready_d = 1'b1;
                w_state_d     = StWaitDone;
                w_cnt_d       = '0;
            end
            StWaitDone, StCapture: begin
                // A capture on the watchdog's final cycle still counts.
                if (i_tpu_done && !w_buf_full) begin
                    w_buf_wr = 1'b1;
                    if (r_cnt == CNT_W'(RESULT_LEN - 1)) begin
                        w_state_d = StDrain;
                        w_cnt_d   = '0;
                    end else begin
                        w_state_d = StCapture;
                        w_cnt_d   = r_cnt + 1'b1;
                    end
                end else if (w_timeout) begin
                    w_error_d = 1'b1;
                    w_state_d = StIdle;
                end
            end
            StDrain: begin
                w_res_valid_d = !w_buf_empty;
                if (w_res_hs) begin
                    w_buf_rd = 1'b1;
                    if (r_cnt == CNT_W'(RESULT_LEN - 1)) begin
                        w_state_d     = StIdle;
                        w_res_valid_d = 1'b0;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    tpu_host_result_buf #(
        .RESULT_LEN (RESULT_LEN)
    ) u_result_buf (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (w_buf_clear),
        .i_wr_en   (w_buf_wr),
        .i_wr_data (i_tpu_result),
        .i_rd_en   (w_buf_rd),
        .o_rd_data (w_buf_rd_data),
        .o_full    (w_buf_full),
        .o_empty   (w_buf_empty)
    );

    assign o_res_data          = r_res_valid ? w_buf_rd_data : '0;
    assign o_res_valid         = r_res_valid;
    assign o_tpu_insert_kernal = r_ins_k;
    assign o_tpu_insert_matrix = r_ins_m;
    assign o_tpu_ready         = r_tpu_ready;
    assign o_tpu_data          = r_tpu_data;
    assign o_error             = r_error;

endmodule

// File: tb/tb_tpu_host_driver.sv
// Self-checking bench for tpu_host_driver: job vector table, hand sequences, random jobs.
// The watchdog sequence runs only when TPU_HOST_TIMEOUT_EN is defined.
module tb_tpu_host_driver;
    import tpu_host_pkg::*;

    localparam int K   = 4;
    localparam int M   = 16;
    localparam int R   = 9;
    localparam int TMO = 32;

    logic  clock = 1'b0;
    logic  reset_n;
    logic  i_start;
    logic  o_busy;
    byte_t i_in_data;
    logic  i_in_valid;
    logic  o_in_ready;
    byte_t o_res_data;
    logic  o_res_valid;
    logic  i_res_ready;
    logic  o_ins_k;
    logic  o_ins_m;
    logic  o_tpu_ready;
    byte_t o_tpu_data;
    logic  i_tpu_done;
    byte_t i_tpu_result;
    logic  o_error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    tpu_host_driver #(
        .KERNEL_LEN     (K),
        .MATRIX_LEN     (M),
        .RESULT_LEN     (R),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clock             (clock),
        .i_reset_n           (reset_n),
        .i_start             (i_start),
        .o_busy              (o_busy),
        .i_in_data           (i_in_data),
        .i_in_valid          (i_in_valid),
        .o_in_ready          (o_in_ready),
        .o_res_data          (o_res_data),
        .o_res_valid         (o_res_valid),
        .i_res_ready         (i_res_ready),
        .o_tpu_insert_kernal (o_ins_k),
        .o_tpu_insert_matrix (o_ins_m),
        .o_tpu_ready         (o_tpu_ready),
        .o_tpu_data          (o_tpu_data),
        .i_tpu_done          (i_tpu_done),
        .i_tpu_result        (i_tpu_result),
        .o_error             (o_error)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Pin-side reference: job bytes still owed, last accepted byte, and the
    // two-cycle delay from the final accepted byte to the tpu_ready pulse.
    int    m_need   = 0;
    bit    prev_acc = 0;
    int    prev_pos = 0;
    byte_t last_b   = '0;
    bit    fin_d1   = 0;
    bit    fin_d2   = 0;
    byte_t pin_k[$];
    byte_t pin_m[$];

    always @(negedge clock) begin
        if (!reset_n) begin
            m_need   = 0;
            prev_acc = 0;
            prev_pos = 0;
            last_b   = '0;
            fin_d1   = 0;
            fin_d2   = 0;
        end else begin
            check("in_ready", int'(o_in_ready), int'(m_need > 0));
            check("ins_kernal", int'(o_ins_k), int'(prev_acc && prev_pos < K));
            check("ins_matrix", int'(o_ins_m), int'(prev_acc && prev_pos >= K));
            check("tpu_data", int'(o_tpu_data), int'(last_b));
            check("tpu_ready", int'(o_tpu_ready), int'(fin_d2));
            if (o_ins_k) pin_k.push_back(o_tpu_data);
            if (o_ins_m) pin_m.push_back(o_tpu_data);
            fin_d2   = fin_d1;
            fin_d1   = 0;
            prev_acc = 0;
            if (i_in_valid && o_in_ready && m_need > 0) begin
                prev_acc = 1;
                prev_pos = K + M - m_need;
                last_b   = i_in_data;
                fin_d1   = (m_need == 1);
                m_need--;
            end
            if (i_start && !o_busy) m_need = K + M;
        end
    end

    byte_t job_in [K+M];
    byte_t res_src [R];
    byte_t got[$];

    task automatic start_job(input bit with_byte);
        check("busy_before_start", int'(o_busy), 0);
        i_start = 1'b1;
        if (with_byte) begin
            i_in_valid = 1'b1;
            i_in_data  = 8'h55;
        end
        step();
        i_start    = 1'b0;
        i_in_valid = 1'b0;
        check("busy_after_start", int'(o_busy), 1);
    endtask

    task automatic feed(input logic [7:0] imask, input int n_bytes);
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < n_bytes && cyc < 400) begin
            i_in_valid   = imask[cyc % 8];
            i_in_data    = i_in_valid ? job_in[idx] : 8'($urandom);
            i_tpu_done   = 1'b1;
            i_tpu_result = 8'hEE;
            acc          = i_in_valid && o_in_ready;
            step();
            if (acc) idx++;
            cyc++;
        end
        i_in_valid = 1'b0;
        i_tpu_done = 1'b0;
        if (idx < n_bytes) check("feed_bound", idx, n_bytes);
    endtask

    task automatic wait_tpu_ready();
        int cyc = 0;
        while (!o_tpu_ready && cyc < 10) begin
            i_tpu_done   = 1'b1;
            i_tpu_result = 8'hEE;
            step();
            cyc++;
        end
        i_tpu_done = 1'b0;
        if (!o_tpu_ready) check("tpu_ready_bound", int'(o_tpu_ready), 1);
    endtask

    task automatic run_job(input bit with_byte, input logic [7:0] imask,
                           input logic [7:0] dmask, input logic [7:0] rmask,
                           input bit start_in_drain);
        int  k;
        int  cyc;
        bit  held;
        byte_t held_data;
        pin_k.delete();
        pin_m.delete();
        got.delete();
        start_job(with_byte);
        feed(imask, K + M);
        wait_tpu_ready();
        k   = 0;
        cyc = 0;
        while (k < R && cyc < 200) begin
            i_tpu_done   = dmask[cyc % 8];
            i_tpu_result = i_tpu_done ? res_src[k] : 8'hEE;
            step();
            if (i_tpu_done) k++;
            cyc++;
        end
        check("res_valid_early", int'(o_res_valid), 0);
        cyc  = 0;
        held = 0;
        held_data = '0;
        while (got.size() < R && cyc < 200) begin
            i_res_ready  = rmask[cyc % 8];
            i_start      = start_in_drain && (cyc == 1);
            i_tpu_done   = 1'b1;
            i_tpu_result = 8'hEE;
            if (held) begin
                check("res_hold_data", int'(o_res_data), int'(held_data));
                check("res_hold_valid", int'(o_res_valid), 1);
            end
            held      = o_res_valid && !i_res_ready;
            held_data = o_res_data;
            if (o_res_valid && i_res_ready) got.push_back(o_res_data);
            step();
            cyc++;
        end
        i_res_ready = 1'b0;
        i_start     = 1'b0;
        i_tpu_done  = 1'b0;
        check("res_count", got.size(), R);
        for (int i = 0; i < R && i < got.size(); i++) check("res_byte", int'(got[i]), int'(res_src[i]));
        check("res_valid_after", int'(o_res_valid), 0);
        check("busy_after", int'(o_busy), 0);
        step();
        check("busy_stays_idle", int'(o_busy), 0);
        check("error_clear", int'(o_error), 0);
        check("kernel_count", pin_k.size(), K);
        check("matrix_count", pin_m.size(), M);
        for (int i = 0; i < K && i < pin_k.size(); i++) check("kernel_byte", int'(pin_k[i]), int'(job_in[i]));
        for (int i = 0; i < M && i < pin_m.size(); i++) check("matrix_byte", int'(pin_m[i]), int'(job_in[K+i]));
    endtask

    typedef struct {
        bit         with_byte;
        logic [7:0] imask;
        logic [7:0] dmask;
        logic [7:0] rmask;
        bit         start_in_drain;
        byte_t      k0;
        byte_t      m0;
        byte_t      r0;
        int         exp_nres;
        byte_t      exp_res_last;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation did not finish in time");
        $fatal(1, "time limit");
    end

    initial begin
        reset_n      = 1'b0;
        i_start      = 1'b0;
        i_in_data    = '0;
        i_in_valid   = 1'b0;
        i_res_ready  = 1'b0;
        i_tpu_done   = 1'b0;
        i_tpu_result = '0;

        // Job vectors: {start+byte, in_valid mask, done mask, res_ready mask, start in drain,
        // kernel base, matrix base, result base} -> {result count, last result byte}.
        vecs[0] = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'h10, 8'hA0, R, 8'hA8};
        vecs[1] = '{1'b0, 8'h55, 8'hFF, 8'hFF, 1'b0, 8'h21, 8'h30, 8'hC0, R, 8'hC8};
        vecs[2] = '{1'b0, 8'hFF, 8'h6D, 8'hF0, 1'b0, 8'h01, 8'h10, 8'hB0, R, 8'hB8};
        vecs[3] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h61, 8'h70, 8'hD0, R, 8'hD8};
        vecs[4] = '{1'b0, 8'hAA, 8'h93, 8'h5B, 1'b1, 8'h81, 8'h90, 8'hE0, R, 8'hE8};

        step();
        step();
        check("rst_busy", int'(o_busy), 0);
        check("rst_in_ready", int'(o_in_ready), 0);
        check("rst_res_valid", int'(o_res_valid), 0);
        check("rst_res_data", int'(o_res_data), 0);
        check("rst_ins_k", int'(o_ins_k), 0);
        check("rst_ins_m", int'(o_ins_m), 0);
        check("rst_tpu_ready", int'(o_tpu_ready), 0);
        check("rst_tpu_data", int'(o_tpu_data), 0);
        check("rst_error", int'(o_error), 0);
        reset_n = 1'b1;
        step();

        // Abort in MATRIX: every output drops at the reset edge, not the clock edge.
        for (int i = 0; i < K + M; i++) job_in[i] = 8'(8'h40 + i);
        start_job(1'b0);
        feed(8'hFF, K + 5);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(o_busy), 0);
        check("mid_rst_in_ready", int'(o_in_ready), 0);
        check("mid_rst_ins_m", int'(o_ins_m), 0);
        check("mid_rst_tpu_data", int'(o_tpu_data), 0);
        check("mid_rst_res_valid", int'(o_res_valid), 0);
        check("mid_rst_tpu_ready", int'(o_tpu_ready), 0);
        step();
        step();
        reset_n = 1'b1;
        step();

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < K; i++) job_in[i] = 8'(vecs[v].k0 + i);
            for (int i = 0; i < M; i++) job_in[K+i] = 8'(vecs[v].m0 + i);
            for (int i = 0; i < R; i++) res_src[i] = 8'(vecs[v].r0 + i);
            run_job(vecs[v].with_byte, vecs[v].imask, vecs[v].dmask, vecs[v].rmask,
                    vecs[v].start_in_drain);
            check("vec_nres", got.size(), vecs[v].exp_nres);
            if (got.size() == R) check("vec_last", int'(got[R-1]), int'(vecs[v].exp_res_last));
        end

        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < K + M; i++) job_in[i] = 8'($urandom);
            for (int i = 0; i < R; i++) res_src[i] = 8'($urandom);
            run_job(1'($urandom), 8'($urandom) | 8'h01, 8'($urandom) | 8'h01,
                    8'($urandom) | 8'h01, 1'($urandom));
        end

`ifdef TPU_HOST_TIMEOUT_EN
        // Chip never answers: error rises exactly TMO cycles after the tpu_ready pulse.
        for (int i = 0; i < K + M; i++) job_in[i] = 8'(i);
        start_job(1'b0);
        feed(8'hFF, K + M);
        wait_tpu_ready();
        for (int c = 1; c <= TMO; c++) begin
            step();
            if (c == TMO - 1) begin
                check("tmo_error_early", int'(o_error), 0);
                check("tmo_busy_early", int'(o_busy), 1);
            end
        end
        check("tmo_error", int'(o_error), 1);
        check("tmo_busy", int'(o_busy), 0);
        for (int c = 0; c < 3; c++) begin
            check("tmo_res_valid", int'(o_res_valid), 0);
            check("tmo_error_sticky", int'(o_error), 1);
            step();
        end
        start_job(1'b0);
        check("tmo_error_cleared", int'(o_error), 0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tpu_host_driver.md
# tpu_host_driver

Host-side driver for the TPU chip pin interface. It is the far end of the byte-wide link into the chip. It accepts a job as a valid/ready byte stream (kernel bytes, then matrix bytes) and drives the chip's `insert_kernal`, `insert_matrix`, `ready` and data pins. It then waits for `done`, captures the result bytes the chip emits, and replays them to the host over a valid/ready result stream.

## Interface
- `KERNEL_LEN`, default 4: kernel bytes per job.
- `MATRIX_LEN`, default 16: matrix bytes per job.
- `RESULT_LEN`, default 9: result bytes per job.
- `TIMEOUT_CYCLES`, default 1024: the watchdog limit, counted from the `tpu_ready` pulse.
- `clock` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse that begins a job; honoured only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `in_data` in 8: job byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: high only in KERNEL and MATRIX.
- `res_data` out 8: result byte.
- `res_valid` out 1: `res_data` is valid.
- `res_ready` in 1: the host takes the result byte.
- `tpu_insert_kernal` out 1: drives chip `io_in[0]`.
- `tpu_insert_matrix` out 1: drives chip `io_in[1]`.
- `tpu_ready` out 1: drives chip `io_in[2]`.
- `tpu_data` out 8: drives chip `io_in[11:4]`.
- `tpu_done` in 1: from chip `io_out[0]`.
- `tpu_result` in 8: from chip `io_out[11:4]`.
- `error` out 1: sticky timeout flag.

## Operation
- States: IDLE, KERNEL, MATRIX, GO, WAIT_DONE, CAPTURE, DRAIN.
- IDLE
  - `start` moves the FSM to KERNEL, clears `error` and zeroes the byte counter.
  - `in_ready` is 0 here, so a byte offered in the same cycle as `start` is not taken.
- KERNEL
  - Each accepted byte (`in_valid && in_ready`) is registered onto `tpu_data` with `tpu_insert_kernal`=1 for exactly one cycle.
  - In a cycle with no accepted byte, all three strobes are 0 and `tpu_data` holds its last value.
  - After the `KERNEL_LEN`-th byte, the FSM moves to MATRIX and the counter resets.
- MATRIX: same as KERNEL, using `tpu_insert_matrix`, for `MATRIX_LEN` bytes, then moves to GO.
- GO: `tpu_ready`=1 for one cycle, then the FSM moves to WAIT_DONE.
- WAIT_DONE
  - On the first cycle with `tpu_done`=1, `tpu_result` is captured as result byte 0 and the FSM moves to CAPTURE.
- CAPTURE
  - Each further cycle with `tpu_done`=1 captures the next byte.
  - Cycles with `tpu_done`=0 are skipped; no byte is captured.
  - After `RESULT_LEN` bytes are captured, the FSM moves to DRAIN.
  - If `RESULT_LEN`=1, the FSM goes straight from WAIT_DONE to DRAIN.
- DRAIN
  - `res_valid`=1 with bytes presented in capture order.
  - The read index advances on each `res_valid && res_ready`.
  - After the last handshake, the FSM returns to IDLE and `res_valid` drops in the following cycle.
- `tpu_done` and `tpu_result` are sampled only in WAIT_DONE and CAPTURE; they are ignored in all other states.
- `start` outside IDLE is ignored.
- Counter widths are `$clog2` of the respective length, with a minimum of 1 bit.

## Timing
- Reset values: every output is 0 (`busy`, `in_ready`, `res_valid`, `res_data`, all `tpu_*` outputs, `error`); the FSM is in IDLE.
- Reset mid-job aborts immediately; captured data is discarded.
- Latency from an accepted input byte to the chip pins: 1 cycle, because the pin outputs are registered.
- `in_ready` is a combinational decode of the state, with no dependence on `in_valid`.
- `tpu_ready` is asserted 1 cycle after the final matrix byte appears on the pins.
- Capture takes a byte in the same clock edge that samples `tpu_done`=1; no synchroniser, because the chip shares `clock`.
- A DRAIN byte is presented the cycle after DRAIN is entered or after the previous handshake. Throughput is 1 byte per cycle while `res_ready` is held high.
- `busy` is 1 in all states except IDLE.

## Configuration
- Macro: `TPU_HOST_TIMEOUT_EN`.
- When defined
  - A watchdog counter starts at the `tpu_ready` pulse.
  - If `RESULT_LEN` bytes are not captured within `TIMEOUT_CYCLES` cycles, `error` is set, the FSM goes to IDLE, and partial results are discarded (`res_valid` is never raised).
  - `error` stays set until the next accepted `start`.
- When undefined: no counter is built, `error` is tied to 0, and the FSM waits indefinitely in WAIT_DONE/CAPTURE.

## Structure
- Package `tpu_host_pkg`: the state enum typedef, default length constants, and the byte typedef `logic [7:0]`.
- Sub-module `tpu_host_result_buf`
  - `RESULT_LEN`×8 register file with a write index and a read index.
  - Write port is driven by CAPTURE; read port by DRAIN.
  - Interface: `clear`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty`.
- All control stays in the top module's FSM.

## Test plan
1. **Full job, no stalls.**
   - Stimulus: `start`; bytes 0x01..0x04 then 0x10..0x1F with `in_valid` high continuously.
   - Required: `tpu_insert_kernal` is high for 4 consecutive cycles carrying 0x01..0x04, then `tpu_insert_matrix` for 16 cycles carrying 0x10..0x1F, then a 1-cycle `tpu_ready`.
   - Model drives `tpu_done` for 9 cycles with 0xA0..0xA8; `res_data` then yields 0xA0..0xA8 with `res_ready`=1, and `busy` falls.
2. **Input gaps.**
   - Stimulus: `in_valid` toggled every other cycle.
   - Required: strobes are high only on the cycles after an accepted byte; the byte order is unchanged.
3. **`tpu_done` gaps and result backpressure.**
   - Stimulus: `tpu_done` pattern 1,0,1,1,0,... carrying 0xB0.. on the high cycles; `res_ready` low for 3 cycles in DRAIN.
   - Required: exactly 9 bytes 0xB0..0xB8 are captured; `res_data` holds 0xB0 stable while stalled.
4. **Mid-job reset and late start.**
   - Stimulus: `reset_n` asserted low during MATRIX.
   - Required: all outputs go to 0 asynchronously; a new `start` runs a clean job.
   - Stimulus: `start` pulsed during DRAIN.
   - Required: the pulse is ignored.
5. **Timeout (macro defined, `TIMEOUT_CYCLES`=32).**
   - Stimulus: `tpu_done` never asserted.
   - Required: `error`=1 32 cycles after `tpu_ready`, the FSM returns to IDLE, and `res_valid` stays 0; the next `start` clears `error`.
6. **Same-cycle `start` and byte.**
   - Stimulus: `start` and `in_valid` with 0x55 in the same cycle in IDLE.
   - Required: 0x55 is not accepted; the kernel count begins with the next byte.
